// File: rtl/ring_pkg.sv
// ring_pkg: mode/direction encodings shared by the shift-register counter.
`default_nettype none

package ring_pkg;

  typedef enum logic [1:0] {
    MODE_RING    = 2'b00,
    MODE_JOHNSON = 2'b01,
    MODE_ONEHOT  = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ring_johnson_counter_onehot_check.sv
// onehot_check: flags a vector with exactly one bit set.
`default_nettype none

module onehot_check #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             onehot_o
);

  logic [WIDTH-1:0] vec_m1;

  assign vec_m1   = vec_i - WIDTH'(1);
  assign onehot_o = (vec_i != '0) && ((vec_i & vec_m1) == '0);

endmodule

`default_nettype wire

// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter: parametrised ring / Johnson / self-correcting one-hot
// shift counter with load, direction control and period-completion flag.
`default_nettype none

module ring_johnson_counter
  import ring_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             Dir,
  input  logic [1:0]       Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap,
  output logic             Err
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] anchor_q, anchor_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  mode_e            mode;
  logic             is_onehot;
  logic [WIDTH-1:0] ring_r, ring_l, john_r, john_l;
  logic [WIDTH-1:0] ring_step, john_step;

  assign mode = mode_e'(Mode);

  onehot_check #(
    .WIDTH (WIDTH)
  ) u_onehot_check (
    .vec_i    (q_q),
    .onehot_o (is_onehot)
  );

  assign ring_r = {q_q[0], q_q[WIDTH-1:1]};
  assign ring_l = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign john_r = {~q_q[0], q_q[WIDTH-1:1]};
  assign john_l = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};

  assign ring_step = (Dir == DIR_LEFT) ? ring_l : ring_r;
  assign john_step = (Dir == DIR_LEFT) ? john_l : john_r;

  always_comb begin
    q_d      = q_q;
    anchor_d = anchor_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    if (Load) begin
      q_d      = Din;
      anchor_d = Din;
    end else if (En && (mode != MODE_HOLD)) begin
      case (mode)
        MODE_RING:    q_d = ring_step;
        MODE_JOHNSON: q_d = john_step;
        MODE_ONEHOT: begin
          if (is_onehot) begin
            q_d = ring_step;
          end else begin
            q_d   = SEED;
            err_d = 1'b1;
          end
        end
        default:      q_d = q_q;
      endcase
      // A recovery step never counts as a period completion, even onto the anchor.
      wrap_d = (q_d == anchor_q) && !err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      q_q      <= SEED;
      anchor_q <= SEED;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      anchor_q <= anchor_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign Q    = q_q;
  assign Wrap = wrap_q;
  assign Err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ring_johnson_counter.sv
// Directed bench for ring_johnson_counter (WIDTH=4) with a per-cycle reference model.
`default_nettype none

module tb_ring_johnson_counter;

  localparam int         W    = 4;
  localparam logic [3:0] SEED = 4'b1000;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       En = 1'b0;
  logic       Dir = 1'b0;
  logic [1:0] Mode = 2'b00;
  logic       Load = 1'b0;
  logic [3:0] Din = 4'b0000;
  logic [3:0] Q;
  logic       Wrap;
  logic       Err;

  int n_vec = 0;
  int n_bad = 0;

  ring_johnson_counter #(
    .WIDTH (W),
    .SEED  (SEED)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .En    (En),
    .Dir   (Dir),
    .Mode  (Mode),
    .Load  (Load),
    .Din   (Din),
    .Q     (Q),
    .Wrap  (Wrap),
    .Err   (Err)
  );

  always #5 Clk = ~Clk;

  // Reference model: integer arithmetic on the counter value.
  int  m_q, m_anchor, nxt;
  bit  m_wrap, m_err, m_valid = 0;

  always @(posedge Clk) begin
    m_wrap = 0;
    m_err  = 0;
    if (!Rst_n) begin
      m_q = int'(SEED); m_anchor = int'(SEED); m_valid = 1;
    end else if (Load) begin
      m_q = int'(Din); m_anchor = int'(Din);
    end else if (En && Mode != 2'd3) begin
      if (Mode == 2'd2 && $countones(m_q) != 1) begin
        m_q = int'(SEED); m_err = 1;
      end else begin
        if (Dir == 1'b0) begin
          nxt = m_q / 2;
          if ((Mode == 2'd1) ? (m_q % 2 == 0) : (m_q % 2 == 1)) nxt = nxt + 8;
        end else begin
          nxt = (m_q * 2) % 16;
          if ((Mode == 2'd1) ? (m_q < 8) : (m_q >= 8)) nxt = nxt + 1;
        end
        m_q    = nxt;
        m_wrap = (m_q == m_anchor);
      end
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      n_vec++;
      if (Q !== 4'(m_q) || Wrap !== m_wrap || Err !== m_err) begin
        n_bad++;
        $display("FAIL model t=%0t: got Q=%b Wrap=%b Err=%b, expected Q=%b Wrap=%b Err=%b",
                 $time, Q, Wrap, Err, 4'(m_q), m_wrap, m_err);
      end
    end
  end

  task automatic tick(input logic rst_n, input logic load, input logic en,
                      input logic dir, input logic [1:0] mode, input logic [3:0] din);
    @(negedge Clk);
    #1;
    Rst_n = rst_n; Load = load; En = en; Dir = dir; Mode = mode; Din = din;
    @(posedge Clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [3:0] eq, input logic ew, input logic ee);
    n_vec++;
    if (Q !== eq || Wrap !== ew || Err !== ee) begin
      n_bad++;
      $display("FAIL %s: got Q=%b Wrap=%b Err=%b, expected Q=%b Wrap=%b Err=%b",
               name, Q, Wrap, Err, eq, ew, ee);
    end
  endtask

  logic [3:0] ring_seq [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
  logic [3:0] john_seq [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                               4'b0111, 4'b0011, 4'b0001, 4'b0000};
  logic [3:0] held;

  initial begin
    // Reset
    tick(0, 0, 0, 0, 2'b00, 4'b0000);
    tick(0, 1, 1, 0, 2'b00, 4'b1111);
    lit("reset", 4'b1000, 0, 0);

    // Ring right, wrap every 4th step
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 1, 0, 2'b00, 4'b0000);
      lit("ring_right", ring_seq[i % 4], (i % 4) == 3, 0);
    end

    // Johnson from loaded 0000, wrap on 8th step only
    tick(1, 1, 0, 0, 2'b01, 4'b0000);
    lit("john_load", 4'b0000, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 1, 0, 2'b01, 4'b0000);
      lit("john_step", john_seq[i], i == 7, 0);
    end

    // One-hot recovery from 0110, silent hold while disabled
    tick(1, 1, 1, 0, 2'b10, 4'b0110);
    tick(1, 0, 0, 0, 2'b10, 4'b0000);
    lit("onehot_hold_bad", 4'b0110, 0, 0);
    tick(1, 0, 1, 0, 2'b10, 4'b0000);
    lit("onehot_fix", 4'b1000, 0, 1);
    tick(1, 0, 1, 0, 2'b10, 4'b0000);
    lit("onehot_ring", 4'b0100, 0, 0);
    tick(1, 0, 1, 1, 2'b10, 4'b0000);
    lit("onehot_left", 4'b1000, 0, 0);

    // Correction onto SEED==Anchor asserts Err, not Wrap
    tick(0, 0, 0, 0, 2'b00, 4'b0000);
    tick(1, 0, 1, 0, 2'b01, 4'b0000);
    lit("john_1100", 4'b1100, 0, 0);
    tick(1, 0, 1, 0, 2'b10, 4'b0000);
    lit("fix_to_anchor", 4'b1000, 0, 1);

    // Direction change mid-sequence
    tick(0, 0, 0, 0, 2'b00, 4'b0000);
    tick(1, 0, 1, 0, 2'b00, 4'b0000);
    tick(1, 0, 1, 0, 2'b00, 4'b0000);
    lit("dir_pre", 4'b0010, 0, 0);
    tick(1, 0, 1, 1, 2'b00, 4'b0000);
    lit("dir_left1", 4'b0100, 0, 0);
    tick(1, 0, 1, 1, 2'b00, 4'b0000);
    lit("dir_left2", 4'b1000, 1, 0);

    // Hold via En=0 and Mode=11, then load during hold
    held = Q;
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 0, 2'b00, 4'b0000);
      lit("hold_en0", held, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 1, 1, 2'b11, 4'b0000);
      lit("hold_mode11", held, 0, 0);
    end
    tick(1, 1, 1, 0, 2'b11, 4'b1010);
    lit("load_in_hold", 4'b1010, 0, 0);

    // Degenerate anchor 0000 in ring: wrap on every step
    tick(1, 1, 0, 0, 2'b00, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 1, i[0], 2'b00, 4'b0000);
      lit("degenerate", 4'b0000, 1, 0);
    end

    // Reset overrides load mid-Johnson
    tick(1, 1, 0, 0, 2'b01, 4'b0000);
    tick(1, 0, 1, 0, 2'b01, 4'b0000);
    tick(1, 0, 1, 1, 2'b01, 4'b0000);
    tick(0, 1, 1, 0, 2'b01, 4'b1111);
    lit("reset_over_load", 4'b1000, 0, 0);

    // Asynchronous reset glitch between edges is ignored
    tick(1, 0, 1, 0, 2'b00, 4'b0000);
    lit("pre_glitch", 4'b0100, 0, 0);
    En = 0;
    @(negedge Clk);
    #1 Rst_n = 0;
    #2 Rst_n = 1;
    @(posedge Clk);
    #1;
    lit("async_glitch", 4'b0100, 0, 0);

    tick(1, 0, 0, 0, 2'b00, 4'b0000);
    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
